// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a word-addressed on-chip RAM.
// Serves one INCR/FIXED burst at a time; read/write contention is arbitrated round-robin.
module axi_ram_slave #(
  parameter int unsigned MEM_AW    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rstn,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth = 1 << MEM_AW;

  typedef enum logic [1:0] {StIdle, StRdata, StWdata, StWresp} state_e;

  state_e            state_q, state_d;
  logic              last_rd_q;
  logic [31:0]       addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [3:0]        id_q;
  logic [3:0]        cnt_q;
  logic              err_q;
  logic              werr_q;

  logic [31:0]       mem [Depth];

  logic              grant_rd;
  logic              ar_hs, aw_hs, r_hs, w_hs;
  logic              last_beat;
  logic [MEM_AW-1:0] widx;

  assign widx      = addr_q[MEM_AW+1:2];
  assign last_beat = (cnt_q == len_q);
  assign ar_hs     = arvalid & arready;
  assign aw_hs     = awvalid & awready;
  assign r_hs      = rvalid & rready;
  assign w_hs      = wvalid & wready;

  always_comb begin
    state_d  = state_q;
    grant_rd = arvalid & (~awvalid | ~last_rd_q);
    arready  = 1'b0;
    awready  = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rresp    = 2'b00;
    rid      = 4'd0;
    rdata    = 32'd0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    bid      = 4'd0;
    unique case (state_q)
      StIdle: begin
        arready = grant_rd;
        awready = awvalid & ~grant_rd;
        if (grant_rd)     state_d = StRdata;
        else if (awvalid) state_d = StWdata;
      end
      StRdata: begin
        rvalid = 1'b1;
        rid    = id_q;
        rlast  = last_beat;
        rresp  = err_q ? 2'b10 : 2'b00;
        rdata  = err_q ? 32'd0 : mem[widx];
        if (rready && last_beat) state_d = StIdle;
      end
      StWdata: begin
        wready = 1'b1;
        // Only the beat count ends a burst; a stray wlast just flags an error.
        if (wvalid && last_beat) state_d = StWresp;
      end
      StWresp: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = (err_q | werr_q) ? 2'b10 : 2'b00;
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b0;
      addr_q    <= 32'd0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      id_q      <= 4'd0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        addr_q    <= araddr;
        len_q     <= arlen;
        size_q    <= arsize;
        burst_q   <= arburst;
        id_q      <= arid;
        cnt_q     <= 4'd0;
        err_q     <= (arburst == 2'b11) | (arsize > 3'b010);
        last_rd_q <= 1'b1;
      end else if (aw_hs) begin
        addr_q    <= awaddr;
        len_q     <= awlen;
        size_q    <= awsize;
        burst_q   <= awburst;
        id_q      <= awid;
        cnt_q     <= 4'd0;
        err_q     <= (awburst == 2'b11) | (awsize > 3'b010);
        werr_q    <= 1'b0;
        last_rd_q <= 1'b0;
      end else if ((r_hs | w_hs) & ~last_beat) begin
        cnt_q <= cnt_q + 4'd1;
        // WRAP is served as INCR; FIXED holds the address.
        if (burst_q != 2'b00) addr_q <= addr_q + (32'd1 << size_q);
      end
      if (w_hs && (wlast != last_beat)) werr_q <= 1'b1;
    end
  end

  // No reset on the array: contents survive rstn.
  always_ff @(posedge clk) begin
    if (rstn && w_hs && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: stimulus pushes expected R beats and B responses,
// a forked monitor pops and compares whenever the DUT completes a handshake.
module tb_axi_ram_slave;

  logic        clk, rstn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_ram_slave #(.MEM_AW(12), .INIT_FILE("")) dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model [4096];
  logic [31:0] wbuf [16];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout_fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got no handshake, expected one (t=%0t)", name, $time);
  endfunction

  task automatic monitor();
    rbeat_t      e;
    bexp_t       be;
    logic        stall_v;
    logic [38:0] stall_s;
    stall_v = 1'b0;
    stall_s = '0;
    forever begin
      @(negedge clk);
      if (stall_v && rvalid) chk("r_stable", {rid, rdata, rresp, rlast}, stall_s);
      stall_v = rvalid && !rready;
      stall_s = {rid, rdata, rresp, rlast};
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
        else begin
          e = rq.pop_front();
          chk("r_beat", {rid, rdata, rresp, rlast}, e);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else begin
          be = bq.pop_front();
          chk("b_resp", {bid, bresp}, be);
        end
      end
    end
  endtask

  task automatic wait_ar();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_aw();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) timeout_fail("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic wait_rq_empty(input bit toggle);
    int n;
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      if (toggle) rready = ~rready;
      n++;
    end
    if (rq.size() != 0) timeout_fail("r_drain");
    rready = 1'b1;
  endtask

  task automatic wait_bq_empty();
    int n;
    n = 0;
    while (bq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bq.size() != 0) timeout_fail("b_drain");
  endtask

  // Pushes the expected beats, performs the AR handshake, and returns at the next negedge.
  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    bit          err;
    rbeat_t      e;
    a   = addr;
    err = (burst == 2'b11) || (size > 3'd2);
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.data = err ? 32'd0 : model[a[13:2]];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    wait_ar();
    @(negedge clk);
    chk("r_latency", rvalid, 1'b1);
  endtask

  task automatic w_beats(input logic [3:0] len, input bit gap, input int early,
                         input logic [3:0] strb);
    int n;
    for (int k = 0; k <= int'(len); k++) begin
      if (gap && k > 0) begin @(posedge clk); #1; end
      wvalid = 1'b1;
      wdata  = wbuf[k];
      wstrb  = strb;
      wlast  = (early >= 0) ? (k == early) : (k == int'(len));
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      if (!wready) timeout_fail("w_beat");
      @(posedge clk); #1;
      wvalid = 1'b0;
      wlast  = 1'b0;
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] strb, input bit gap, input int early,
                             input logic [1:0] exp_resp);
    logic [31:0] a;
    bit          err;
    bexp_t       be;
    be.id   = id;
    be.resp = exp_resp;
    bq.push_back(be);
    a   = addr;
    err = (burst == 2'b11) || (size > 3'd2);
    for (int k = 0; k <= int'(len); k++) begin
      if (!err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) model[a[13:2]][8*b +: 8] = wbuf[k][8*b +: 8];
        end
      end
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    wait_aw();
    w_beats(len, gap, early, strb);
    wait_bq_empty();
  endtask

  initial begin
    rbeat_t e;
    bexp_t  be;
    rstn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (int i = 0; i < 4096; i++) model[i] = 32'd0;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rid", rid, 4'd0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_bid", bid, 4'd0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Preload words 0x40..0x47 = 0xA0..0xA7, then an 8-beat INCR read
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hA0 + k;
    write_burst(4'd3, 32'h100, 4'd7, 3'd2, 2'b01, 4'hF, 1'b0, -1, 2'b00);
    ar_issue(4'd5, 32'h100, 4'd7, 3'd2, 2'b01);
    wait_rq_empty(1'b0);

    // Gapped write at 0x200, plain readback, then readback with rready toggling
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h11111111 * (k + 1);
    write_burst(4'd6, 32'h200, 4'd7, 3'd2, 2'b01, 4'hF, 1'b1, -1, 2'b00);
    ar_issue(4'd7, 32'h200, 4'd7, 3'd2, 2'b01);
    wait_rq_empty(1'b0);
    ar_issue(4'd8, 32'h200, 4'd7, 3'd2, 2'b01);
    wait_rq_empty(1'b1);

    // Byte-lane write into 0xDEADBEEF
    wbuf[0] = 32'hDEADBEEF;
    write_burst(4'd1, 32'h300, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0, -1, 2'b00);
    wbuf[0] = 32'h00AB0000;
    write_burst(4'd2, 32'h300, 4'd0, 3'd0, 2'b01, 4'b0100, 1'b0, -1, 2'b00);
    e = '{id: 4'd4, data: 32'hDEABBEEF, resp: 2'b00, last: 1'b1};
    rq.push_back(e);
    arid = 4'd4; araddr = 32'h300; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    wait_ar();
    wait_rq_empty(1'b0);

    // Simultaneous AR/AW straight out of reset: read first, write right after
    rstn = 1'b0;
    arid = 4'd9; araddr = 32'h100; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'd10; awaddr = 32'h500; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    e = '{id: 4'd9, data: 32'hA0, resp: 2'b00, last: 1'b1};
    rq.push_back(e);
    be = '{id: 4'd10, resp: 2'b00};
    bq.push_back(be);
    model[12'h140] = 32'h55;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("pair1_arready", arready, 1'b1);
    chk("pair1_awready", awready, 1'b0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pair1_aw_next", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wbuf[0] = 32'h55;
    w_beats(4'd0, 1'b0, -1, 4'hF);
    wait_bq_empty();
    wait_rq_empty(1'b0);

    // Lone read leaves last_rd set, so the next tie goes to the write
    ar_issue(4'd11, 32'h500, 4'd0, 3'd2, 2'b01);
    wait_rq_empty(1'b0);
    arid = 4'd12; araddr = 32'h300; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'd13; awaddr = 32'h504; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    be = '{id: 4'd13, resp: 2'b00};
    bq.push_back(be);
    model[12'h141] = 32'h66;
    e = '{id: 4'd12, data: 32'hDEABBEEF, resp: 2'b00, last: 1'b1};
    rq.push_back(e);
    @(negedge clk);
    chk("pair2_awready", awready, 1'b1);
    chk("pair2_arready", arready, 1'b0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wbuf[0] = 32'h66;
    w_beats(4'd0, 1'b0, -1, 4'hF);
    wait_bq_empty();
    wait_ar();
    wait_rq_empty(1'b0);
    ar_issue(4'd0, 32'h504, 4'd0, 3'd2, 2'b01);
    wait_rq_empty(1'b0);

    // Early wlast: all four beats still taken, SLVERR response
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE0000 + k;
    write_burst(4'd14, 32'h600, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0, 1, 2'b10);

    // Reserved burst type: zero data, SLVERR on every beat
    ar_issue(4'd15, 32'h100, 4'd3, 3'd2, 2'b11);
    wait_rq_empty(1'b0);

    // Reset during beat 3 of an 8-beat read, then a fresh read
    ar_issue(4'd6, 32'h100, 4'd7, 3'd2, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    rready = 1'b0;
    @(posedge clk); #1;
    rq.delete();
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rready = 1'b1;
    ar_issue(4'd2, 32'h100, 4'd1, 3'd2, 2'b01);
    wait_rq_empty(1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
